// File: rtl/sw_debounce_if.sv
// Switch conditioner bus: raw pins in, debounced state and edge pulses out.
interface sw_debounce_if #(
  parameter int unsigned WIDTH = 16
);
  logic [WIDTH-1:0] sw_in;
  logic [WIDTH-1:0] sw_out;
  logic [WIDTH-1:0] sw_rise;
  logic [WIDTH-1:0] sw_fall;
  logic             sw_changed;

  modport master (
    output sw_in,
    input  sw_out, sw_rise, sw_fall, sw_changed
  );

  modport slave (
    input  sw_in,
    output sw_out, sw_rise, sw_fall, sw_changed
  );
endinterface

// File: rtl/sw_debounce.sv
// Per-bit synchronizer and debouncer for board switches, with registered
// rise/fall/change pulses for the cpu I/O read path.
module sw_debounce #(
  parameter int unsigned WIDTH           = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 250000, // 1 .. 2^24-1
  parameter int unsigned SYNC_STAGES     = 2       // 2 .. 4
) (
  input  logic          clk,
  input  logic          rst,
  sw_debounce_if.slave  sw
);

  localparam int unsigned CW   = $clog2(DEBOUNCE_CYCLES + 1);
  // Pin sample flop ahead of the SYNC_STAGES chain: a step captured at edge N
  // reaches sw_out at edge N+SYNC_STAGES+DEBOUNCE_CYCLES.
  localparam int unsigned NSTG = SYNC_STAGES + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [NSTG-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]           s;

  logic [WIDTH-1:0][CW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]           out_q, out_d;
  logic [WIDTH-1:0]           rise_q, rise_d;
  logic [WIDTH-1:0]           fall_q, fall_d;
  logic                       changed_q, changed_d;

  assign s = sync_q[NSTG-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[NSTG-2:0], sw.sw_in};
    end
  end

  // Counter restarts whenever the synchronized bit agrees with sw_out.
  always_comb begin
    cnt_d = cnt_q;
    out_d = out_q;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (s[i] == out_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        out_d[i] = s[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  assign rise_d    = out_d & ~out_q;
  assign fall_d    = ~out_d & out_q;
  assign changed_d = |(rise_d | fall_d);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      out_q     <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
      changed_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      out_q     <= out_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      changed_q <= changed_d;
    end
  end

  assign sw.sw_out     = out_q;
  assign sw.sw_rise    = rise_q;
  assign sw.sw_fall    = fall_q;
  assign sw.sw_changed = changed_q;

endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce: D=4 main instance plus a D=1 latency instance.
module tb_sw_debounce;

  logic clk;
  logic rst;

  sw_debounce_if #(.WIDTH(16)) sw4 ();
  sw_debounce_if #(.WIDTH(16)) sw1 ();

  sw_debounce #(.WIDTH(16), .DEBOUNCE_CYCLES(4), .SYNC_STAGES(2)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .sw  (sw4.slave)
  );

  sw_debounce #(.WIDTH(16), .DEBOUNCE_CYCLES(1), .SYNC_STAGES(2)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .sw  (sw1.slave)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Advance one active edge and settle just past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int rise_cnt, fall_cnt, chg_cnt, rise_at;
    logic seen;

    rst = 1'b0;
    sw4.sw_in = 16'h0000;
    sw1.sw_in = 16'h0000;

    // Reset hold
    #90;
    check("rst_out",     32'(sw4.sw_out),     32'h0);
    check("rst_rise",    32'(sw4.sw_rise),    32'h0);
    check("rst_fall",    32'(sw4.sw_fall),    32'h0);
    check("rst_changed", 32'(sw4.sw_changed), 32'h0);
    check("rst_out_d1",  32'(sw1.sw_out),     32'h0);

    // Latency: release and step bit 0 before edge N (t=140)
    #20;
    rst = 1'b1;
    sw4.sw_in = 16'h0001;
    sw1.sw_in = 16'h0001;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 3) check("d1_out_n2", 32'(sw1.sw_out), 32'h0);
      if (k == 4) check("d1_out_n3", 32'(sw1.sw_out), 32'h1);
      if (k == 6) check("lat_out_n5", 32'(sw4.sw_out), 32'h0);
      if (k == 7) begin
        check("lat_out_n6",     32'(sw4.sw_out),     32'h1);
        check("lat_rise_n6",    32'(sw4.sw_rise),    32'h1);
        check("lat_fall_n6",    32'(sw4.sw_fall),    32'h0);
        check("lat_changed_n6", 32'(sw4.sw_changed), 32'h1);
      end
      if (k == 8) begin
        check("lat_out_n7",     32'(sw4.sw_out),     32'h1);
        check("lat_rise_n7",    32'(sw4.sw_rise),    32'h0);
        check("lat_changed_n7", 32'(sw4.sw_changed), 32'h0);
      end
    end

    // Return bit 0 low; expect exactly one fall pulse
    sw4.sw_in = 16'h0000;
    fall_cnt = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (sw4.sw_fall[0]) fall_cnt++;
    end
    check("ret_fall_cnt", 32'(fall_cnt),   32'd1);
    check("ret_out",      32'(sw4.sw_out), 32'h0);

    // Glitch: bit 3 high for 3 captured edges only
    sw4.sw_in = 16'h0008;
    for (int k = 1; k <= 3; k++) tick();
    sw4.sw_in = 16'h0000;
    seen = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (sw4.sw_out[3] || sw4.sw_rise[3] || sw4.sw_changed) seen = 1'b1;
    end
    check("glitch_seen", 32'(seen), 32'h0);

    // Bounce on bit 7, then hold high
    sw4.sw_in = 16'h0080; tick();
    sw4.sw_in = 16'h0000; tick();
    sw4.sw_in = 16'h0080; tick();
    sw4.sw_in = 16'h0000; tick();
    sw4.sw_in = 16'h0080;
    rise_cnt = 0;
    fall_cnt = 0;
    rise_at  = -1;
    for (int k = 1; k <= 15; k++) begin
      tick();
      if (sw4.sw_rise[7]) begin
        rise_cnt++;
        rise_at = k - 1;
      end
      if (sw4.sw_fall[7]) fall_cnt++;
    end
    check("bounce_rise_cnt", 32'(rise_cnt),   32'd1);
    check("bounce_rise_at",  32'(rise_at),    32'd6);
    check("bounce_fall_cnt", 32'(fall_cnt),   32'd0);
    check("bounce_out",      32'(sw4.sw_out), 32'h0080);

    // Multi-bit: settle at 00FF then step to FF00
    sw4.sw_in = 16'h00FF;
    for (int k = 1; k <= 10; k++) tick();
    check("multi_pre_out", 32'(sw4.sw_out), 32'h00FF);
    sw4.sw_in = 16'hFF00;
    chg_cnt = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (sw4.sw_changed) chg_cnt++;
      if (k == 6) check("multi_out_n5", 32'(sw4.sw_out), 32'h00FF);
      if (k == 7) begin
        check("multi_out",     32'(sw4.sw_out),     32'hFF00);
        check("multi_rise",    32'(sw4.sw_rise),    32'hFF00);
        check("multi_fall",    32'(sw4.sw_fall),    32'h00FF);
        check("multi_changed", 32'(sw4.sw_changed), 32'h1);
      end
    end
    check("multi_chg_cnt", 32'(chg_cnt), 32'd1);

    // Reset mid-count, asserted between edges
    sw4.sw_in = 16'hFFFF;
    for (int k = 1; k <= 3; k++) tick();
    #10;
    rst = 1'b0;
    #1;
    check("midrst_out",     32'(sw4.sw_out),     32'h0);
    check("midrst_rise",    32'(sw4.sw_rise),    32'h0);
    check("midrst_fall",    32'(sw4.sw_fall),    32'h0);
    check("midrst_changed", 32'(sw4.sw_changed), 32'h0);
    @(posedge clk);
    #5;
    check("midrst_hold_out", 32'(sw4.sw_out), 32'h0);
    #10;
    rst = 1'b1;
    rise_cnt = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (sw4.sw_rise != 16'h0) rise_cnt++;
      if (k == 6) check("rel_out_n5",  32'(sw4.sw_out),  32'h0);
      if (k == 7) check("rel_rise_n6", 32'(sw4.sw_rise), 32'hFFFF);
    end
    check("rel_rise_cnt", 32'(rise_cnt),   32'd1);
    check("rel_out",      32'(sw4.sw_out), 32'hFFFF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
